bcd_bin_conv_ctrl: RTL and testbench

- Sequential, digit-serial BCD-to-binary converter and controller for the calculator input unit.
- Accepts an 11-nibble entry word: 10 magnitude digits plus a sign/marker nibble.
- Produces a 32-bit sign-magnitude result (magnitude plus neg flag) with a start/busy/done handshake.
- Replaces the single-cycle 10-multiplier sum with one multiply-by-10 and add per clock, so the ALU front-end sees a registered, qualified operand.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/bcd_mac10.sv | 24 ++
 rtl/bcd_bin_conv_ctrl.sv | 137 +++++++++++++
 tb/tb_bcd_bin_conv_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator input unit.
// Nibble coding helpers used by the BCD entry converters.
package calc_pkg;

  localparam int BCD_DIGITS = 10;
  localparam int ENTRY_W = 44;
  localparam logic [3:0] NIBBLE_NEG = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } conv_state_t;

  function automatic logic is_bad_digit(
    input logic [3:0] d
  );
    return (d > 4'd9) && (d != NIBBLE_NEG);
  endfunction

  function automatic logic has_neg(
    input logic [ENTRY_W-1:0] w
  );
    logic r;
    r = 1'b0;
    for (int k = 0; k < ENTRY_W / 4; k++) begin
      if (w[4*k +: 4] == NIBBLE_NEG) r = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// Combinational acc*10 + d with carry-out detection.
// The multiply is two shifts and an add, no hard multiplier.
module bcd_mac10 #(
  parameter int W = 32
) (
  input  logic [W-1:0] acc_i,
  input  logic [3:0]   d_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);

  logic [W+3:0] wide;
  logic [W+3:0] ext;

  always_comb begin
    ext = {4'b0000, acc_i};
    wide = (ext << 3) + (ext << 1)
         + {{W{1'b0}}, d_i};
  end

  assign sum_o = wide[W-1:0];
  assign cout_o = |wide[W+3:W];

endmodule

// File: rtl/bcd_bin_conv_ctrl.sv
// Digit-serial BCD entry to sign-magnitude binary converter.
// One multiply-by-10 step per clock, start/busy/done handshake.
module bcd_bin_conv_ctrl
  import calc_pkg::*;
#(
  parameter int NDIG = BCD_DIGITS,
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ENTRY_W-1:0] bcd_in,
  output logic               busy,
  output logic               done,
  output logic [W-1:0]       binary_sm,
  output logic               neg,
  output logic               err,
  output logic               ovf
);

  localparam int IW = $clog2(NDIG);

  conv_state_t state_q, state_d;
  logic [4*NDIG-1:0] shadow_q, shadow_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] bin_q, bin_d;
  logic [IW-1:0] idx_q, idx_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic neg_q, neg_d;
  logic err_q, err_d;
  logic ovf_q, ovf_d;

  logic [3:0] nib;
  logic [3:0] dig;
  logic bad;
  logic [W-1:0] mac_sum;
  logic mac_cout;

  always_comb begin
    nib = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx_q == IW'(k)) nib = shadow_q[4*k +: 4];
    end
    bad = is_bad_digit(nib);
    dig = (bad || nib == NIBBLE_NEG) ? 4'd0 : nib;
  end

  bcd_mac10 #(
    .W(W)
  ) u_mac (
    .acc_i (acc_q),
    .d_i   (dig),
    .sum_o (mac_sum),
    .cout_o(mac_cout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      acc_q    <= '0;
      bin_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    idx_d    = idx_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    neg_d    = neg_q;
    err_d    = err_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = bcd_in[4*NDIG-1:0];
          acc_d    = '0;
          err_d    = 1'b0;
          ovf_d    = 1'b0;
          neg_d    = has_neg(bcd_in);
          idx_d    = IW'(NDIG - 1);
          busy_d   = 1'b1;
          state_d  = CONV;
        end
      end
      CONV: begin
        if (bad) err_d = 1'b1;
        // Once saturated, stay saturated for the rest of the word
        if (mac_cout || ovf_q) begin
          ovf_d = 1'b1;
          acc_d = '1;
        end else begin
          acc_d = mac_sum;
        end
        if (idx_q == '0) state_d = DONE;
        else idx_d = idx_q - 1'b1;
      end
      DONE: begin
        bin_d   = acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign binary_sm = bin_q;
  assign neg = neg_q;
  assign err = err_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bcd_bin_conv_ctrl.sv
// Directed bench for bcd_bin_conv_ctrl.
// Hand-computed vectors; sampling on the falling edge.
module tb_bcd_bin_conv_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [43:0] bcd_in;
  logic busy, done, neg, err, ovf;
  logic [31:0] binary_sm;

  int errors = 0;
  int checks = 0;

  bcd_bin_conv_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .binary_sm(binary_sm),
    .neg      (neg),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] to_bcd(input int v);
    logic [43:0] w;
    int t;
    w = '0;
    t = v;
    for (int k = 0; k < 10; k++) begin
      w[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return w;
  endfunction

  function automatic int val(input int i);
    return 1000 * i + 37;
  endfunction

  // One conversion; optional stray start while busy
  task automatic run(input string tag,
                     input logic [43:0] v,
                     input logic [31:0] e_bin,
                     input logic e_neg, e_err, e_ovf,
                     input logic extra);
    int n;
    int extra_done;
    @(negedge clk);
    start = 1'b1;
    bcd_in = v;
    @(negedge clk);
    start = 1'b0;
    bcd_in = ~v;
    n = 0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    while (!done && n < 40) begin
      start = (extra && n == 4);
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'd11);
    chk({tag, "_bin"}, binary_sm, e_bin);
    chk({tag, "_neg"}, 32'(neg), 32'(e_neg));
    chk({tag, "_err"}, 32'(err), 32'(e_err));
    chk({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
    chk({tag, "_busy0"}, 32'(busy), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done) extra_done++;
    end
    chk({tag, "_ndone"}, 32'(extra_done), 32'd0);
    chk({tag, "_hold"}, binary_sm, e_bin);
  endtask

  initial begin
    int dn;
    int dedge [3];
    logic [31:0] dbin [3];
    int n;
    reset = 1'b1;
    start = 1'b0;
    bcd_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bin", binary_sm, 32'd0);
    chk("rst_flags", {29'd0, neg, err, ovf}, 32'd0);
    reset = 1'b0;

    run("dec", 44'h000_0012_3456, 32'd123456,
        1'b0, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1;
    bcd_in = 44'hE00_0000_0042;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_neg", 32'(neg), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_bin", binary_sm, 32'd0);
    chk("mrst_flags", {29'd0, neg, err, ovf}, 32'd0);

    run("neg10", 44'hE00_0000_0042, 32'd42,
        1'b1, 1'b0, 1'b0, 1'b0);
    run("negin", 44'h000_0000_E007, 32'd7,
        1'b1, 1'b0, 1'b0, 1'b0);
    run("ovf", 44'h042_9496_7329, 32'hFFFF_FFFF,
        1'b0, 1'b0, 1'b1, 1'b0);
    run("max", 44'h042_9496_7295, 32'hFFFF_FFFF,
        1'b0, 1'b0, 1'b0, 1'b0);
    run("ovf9", 44'h099_9999_9999, 32'hFFFF_FFFF,
        1'b0, 1'b0, 1'b1, 1'b0);
    run("err", 44'h000_0000_1A23, 32'd1023,
        1'b0, 1'b1, 1'b0, 1'b1);
    run("zero", 44'h0, 32'd0,
        1'b0, 1'b0, 1'b0, 1'b0);

    // start held high, bcd_in changing every cycle
    dn = 0;
    @(negedge clk);
    start = 1'b1;
    bcd_in = to_bcd(val(0));
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (done && dn < 3) begin
        dedge[dn] = i - 1;
        dbin[dn] = binary_sm;
        dn++;
      end
      if (i < 30) bcd_in = to_bcd(val(i));
      else start = 1'b0;
    end
    chk("b2b_count", 32'(dn), 32'd2);
    if (dn >= 2) begin
      chk("b2b_edge0", 32'(dedge[0]), 32'd11);
      chk("b2b_bin0", dbin[0], 32'(val(0)));
      chk("b2b_edge1", 32'(dedge[1]), 32'd23);
      chk("b2b_bin1", dbin[1], 32'(val(12)));
    end
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_bin2", binary_sm, 32'(val(24)));

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
